// File: rtl/slac_pkg.sv
// Shared types and constants for the partial-sum collector.
package slac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } psum_state_e;

    localparam int unsigned PSUM_DATA_WIDTH   = 16;
    localparam int unsigned PSUM_NUM_PES      = 16;
    localparam int unsigned PSUM_MAX_CHANNELS = 256;

    localparam logic signed [PSUM_DATA_WIDTH-1:0] PSUM_MAX = {1'b0, {(PSUM_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PSUM_DATA_WIDTH-1:0] PSUM_MIN = {1'b1, {(PSUM_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/psum_collector_sat_add.sv
// Combinational signed saturating adder; clamps instead of wrapping.
module sat_add
    import slac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PSUM_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH:0] sum;

    // One guard bit; guard and sign disagreeing means overflow in that direction.
    always_comb begin
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            y = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            y = sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Partial-sum collector: accumulates PE output beats over several channel
// passes into a local tile, then drains it in raster order.
// Optional macro PSUM_RELU_EN: clamp negative drained values to zero.
module psum_collector
    import slac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = PSUM_DATA_WIDTH,
    parameter int unsigned NUM_PES      = PSUM_NUM_PES,
    parameter int unsigned MAX_CHANNELS = PSUM_MAX_CHANNELS,
    parameter int unsigned LOG_NPE      = $clog2(NUM_PES),
    parameter int unsigned CH_W         = $clog2(MAX_CHANNELS) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [LOG_NPE:0]      i_ofmap_data,
    input  logic [CH_W-1:0]       i_num_channels,
    input  logic [DATA_WIDTH-1:0] i_peout_data,
    input  logic                  i_peout_valid,
    input  logic [LOG_NPE:0]      i_peout_row,
    input  logic [LOG_NPE:0]      i_peout_col,
    output logic [DATA_WIDTH-1:0] o_ofmap_data,
    output logic                  o_ofmap_valid,
    input  logic                  i_ofmap_ready,
    output logic                  o_busy,
    output logic                  o_tile_done,
    output logic                  o_overrun
);

    localparam int unsigned IDX_W = LOG_NPE + 1;

    psum_state_e state, state_nxt;

    logic [IDX_W-1:0] ofmap_r, ofmap_last;
    logic [CH_W-1:0]  nch_r, ch_cnt;
    logic [IDX_W-1:0] d_row, d_col;
    logic             all_loaded;

    logic signed [DATA_WIDTH-1:0] tile [NUM_PES][NUM_PES];

    logic accept, pass_end, last_pass, drain_hs, load_en, start_ok;
    logic signed [DATA_WIDTH-1:0] acc_old, acc_sum, wr_val, drain_val;

    sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
        .a (acc_old),
        .b (i_peout_data),
        .y (acc_sum)
    );

    // Beat qualification, write value and drain-side handshake terms.
    always_comb begin
        ofmap_last = ofmap_r - IDX_W'(1);
        start_ok   = (state == IDLE) && i_start;
        accept     = (state == ACCUM) && i_peout_valid &&
                     (i_peout_row < ofmap_r) && (i_peout_col < ofmap_r);
        pass_end   = accept && (i_peout_row == ofmap_last) && (i_peout_col == ofmap_last);
        last_pass  = (ch_cnt == nch_r - CH_W'(1));
        acc_old    = tile[i_peout_row[LOG_NPE-1:0]][i_peout_col[LOG_NPE-1:0]];
        wr_val     = (ch_cnt == '0) ? i_peout_data : acc_sum;
        drain_hs   = o_ofmap_valid && i_ofmap_ready;
        load_en    = (state == DRAIN) && (!o_ofmap_valid || i_ofmap_ready);
        drain_val  = tile[d_row[LOG_NPE-1:0]][d_col[LOG_NPE-1:0]];
`ifdef PSUM_RELU_EN
        if (drain_val[DATA_WIDTH-1]) begin
            drain_val = '0;
        end
`endif
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        o_busy    = (state != IDLE);
        case (state)
            IDLE:    if (i_start) state_nxt = ACCUM;
            ACCUM:   if (pass_end && last_pass) state_nxt = DRAIN;
            DRAIN:   if (drain_hs && all_loaded) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Config latch, pass counter, drain sequencer and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ofmap_r       <= '0;
            nch_r         <= '0;
            ch_cnt        <= '0;
            d_row         <= '0;
            d_col         <= '0;
            all_loaded    <= 1'b0;
            o_ofmap_data  <= '0;
            o_ofmap_valid <= 1'b0;
            o_tile_done   <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            o_tile_done <= (state == DRAIN) && drain_hs && all_loaded;

            if (i_peout_valid && state != ACCUM) o_overrun <= 1'b1;

            if (start_ok) begin
                ofmap_r    <= i_ofmap_data;
                nch_r      <= i_num_channels;
                ch_cnt     <= '0;
                d_row      <= '0;
                d_col      <= '0;
                all_loaded <= 1'b0;
                o_overrun  <= 1'b0;
            end

            if (pass_end && !last_pass) ch_cnt <= ch_cnt + CH_W'(1);

            // Output register refills whenever it is empty or being accepted;
            // once every element is loaded the next refill clears valid instead.
            if (load_en) begin
                if (!all_loaded) begin
                    o_ofmap_data  <= drain_val;
                    o_ofmap_valid <= 1'b1;
                    if (d_col == ofmap_last) begin
                        d_col <= '0;
                        if (d_row == ofmap_last) all_loaded <= 1'b1;
                        else                     d_row <= d_row + IDX_W'(1);
                    end else begin
                        d_col <= d_col + IDX_W'(1);
                    end
                end else begin
                    o_ofmap_valid <= 1'b0;
                end
            end
        end
    end

    // Tile storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            tile[i_peout_row[LOG_NPE-1:0]][i_peout_col[LOG_NPE-1:0]] <= wr_val;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed self-checking bench for psum_collector.
module tb_psum_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_ofmap_data = '0;
    logic [8:0]  i_num_channels = '0;
    logic [15:0] i_peout_data = '0;
    logic        i_peout_valid = 1'b0;
    logic [4:0]  i_peout_row = '0;
    logic [4:0]  i_peout_col = '0;
    logic [15:0] o_ofmap_data;
    logic        o_ofmap_valid;
    logic        i_ofmap_ready = 1'b0;
    logic        o_busy;
    logic        o_tile_done;
    logic        o_overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q [16];
    int cyc;

    psum_collector #(.DATA_WIDTH(16), .NUM_PES(16), .MAX_CHANNELS(256)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_ofmap_data   (i_ofmap_data),
        .i_num_channels (i_num_channels),
        .i_peout_data   (i_peout_data),
        .i_peout_valid  (i_peout_valid),
        .i_peout_row    (i_peout_row),
        .i_peout_col    (i_peout_col),
        .o_ofmap_data   (o_ofmap_data),
        .o_ofmap_valid  (o_ofmap_valid),
        .i_ofmap_ready  (i_ofmap_ready),
        .o_busy         (o_busy),
        .o_tile_done    (o_tile_done),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic int relu(input int v);
`ifdef PSUM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic signed [31:0] sdata();
        return {{16{o_ofmap_data[15]}}, o_ofmap_data};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic start_tile(input int om, input int ch);
        i_start        = 1'b1;
        i_ofmap_data   = om[4:0];
        i_num_channels = ch[8:0];
        @(negedge clk);
        i_start        = 1'b0;
        i_ofmap_data   = 5'd7;
        i_num_channels = 9'd100;
    endtask

    task automatic send(input int r, input int c, input int d);
        i_peout_valid = 1'b1;
        i_peout_row   = r[4:0];
        i_peout_col   = c[4:0];
        i_peout_data  = d[15:0];
        @(negedge clk);
        i_peout_valid = 1'b0;
    endtask

    // Collects n beats under a cyclic 4-entry ready pattern, checking order,
    // hold-while-stalled, the done pulse and the return to idle.
    task automatic drain(input string tag, input int n, input logic [3:0] pat, output int cycles);
        int got = 0;
        int c = 0;
        logic stalled = 1'b0;
        logic signed [31:0] prev = 0;
        while (got < n && c < 300) begin
            i_ofmap_ready = pat[c[1:0]];
            if (stalled) begin
                chk({tag, "_hold_valid"}, o_ofmap_valid, 1);
                chk({tag, "_hold_data"}, sdata(), prev);
            end
            if (o_ofmap_valid && i_ofmap_ready) begin
                chk(tag, sdata(), exp_q[got]);
                got++;
            end
            stalled = o_ofmap_valid && !i_ofmap_ready;
            prev    = sdata();
            @(negedge clk);
            c++;
        end
        cycles = c;
        chk({tag, "_count"}, got, n);
        chk({tag, "_done"}, o_tile_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_valid_end"}, o_ofmap_valid, 0);
        i_ofmap_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, o_tile_done, 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_ofmap_valid, 0);
        chk("rst_done", o_tile_done, 0);
        chk("rst_overrun", o_overrun, 0);
        chk("rst_data", sdata(), 0);
        reset = 1'b0;
        @(negedge clk);

        // 2x2, one pass, ready held high
        start_tile(2, 1);
        chk("t1_busy", o_busy, 1);
        send(0, 0, 1); send(0, 1, 2); send(1, 0, 3); send(1, 1, 4);
        chk("t1_entry_valid", o_ofmap_valid, 0);
        chk("t1_entry_busy", o_busy, 1);
        exp_q[0] = 1; exp_q[1] = 2; exp_q[2] = 3; exp_q[3] = 4;
        drain("t1", 4, 4'b1111, cyc);
        chk("t1_cycles", cyc, 5);

        // 2x2, three passes of +5; stray i_start mid-tile is ignored
        start_tile(2, 3);
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    send(r, c, 5);
            if (p == 0) begin
                i_start = 1'b1; i_ofmap_data = 5'd1; i_num_channels = 9'd1;
                @(negedge clk);
                i_start = 1'b0;
                chk("t2_busy_midtile", o_busy, 1);
            end
        end
        for (int i = 0; i < 4; i++) exp_q[i] = 15;
        drain("t2", 4, 4'b1111, cyc);
        chk("t2_cycles", cyc, 5);

        // Positive saturation, back-to-back beats to one address
        start_tile(1, 2);
        send(0, 0, 32000); send(0, 0, 1000);
        exp_q[0] = 32767;
        drain("t3_satpos", 1, 4'b1111, cyc);

        // Negative saturation
        start_tile(1, 2);
        send(0, 0, -32000); send(0, 0, -1000);
        exp_q[0] = relu(-32768);
        drain("t3_satneg", 1, 4'b1111, cyc);

        // 3x3 with ready toggling 1,0,0,1
        start_tile(3, 1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                send(r, c, 11 + r * 3 + c);
                exp_q[r * 3 + c] = 11 + r * 3 + c;
            end
        drain("t4", 9, 4'b1001, cyc);

        // Beat during drain sets overrun, tile unchanged
        start_tile(2, 1);
        send(0, 0, 10); send(0, 1, 20); send(1, 0, 30); send(1, 1, 40);
        chk("t5_overrun_pre", o_overrun, 0);
        send(0, 0, 99);
        chk("t5_overrun_set", o_overrun, 1);
        exp_q[0] = 10; exp_q[1] = 20; exp_q[2] = 30; exp_q[3] = 40;
        drain("t5", 4, 4'b1111, cyc);
        chk("t5_overrun_sticky", o_overrun, 1);

        // Next start clears overrun; reset on drain beat 2
        start_tile(2, 1);
        chk("t6_overrun_clr", o_overrun, 0);
        send(0, 0, 1); send(0, 1, 2); send(1, 0, 3); send(1, 1, 4);
        i_ofmap_ready = 1'b1;
        @(negedge clk);
        chk("t6_beat1", sdata(), 1);
        @(negedge clk);
        chk("t6_beat2_valid", o_ofmap_valid, 1);
        chk("t6_beat2", sdata(), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_ofmap_ready = 1'b0;
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_valid", o_ofmap_valid, 0);
        chk("t6_rst_done", o_tile_done, 0);
        @(negedge clk);
        chk("t6_rst_done2", o_tile_done, 0);
        chk("t6_rst_busy2", o_busy, 0);

        // Fresh tile after reset: two passes, out-of-range beats dropped
        start_tile(2, 2);
        send(0, 0, 1); send(2, 0, 777); send(0, 1, 2); send(1, 0, 3); send(1, 1, 4);
        chk("t7_busy_p1", o_busy, 1);
        chk("t7_valid_p1", o_ofmap_valid, 0);
        send(0, 3, 555); send(1, 0, 10); send(0, 0, 10); send(0, 1, -20); send(1, 1, 6);
        chk("t7_overrun", o_overrun, 0);
        exp_q[0] = 11; exp_q[1] = relu(-18); exp_q[2] = 13; exp_q[3] = 10;
        drain("t7", 4, 4'b1001, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
